// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART TX arbitration path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } uart_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
// Module   : uart_rr_pick
// Purpose  : Combinational round-robin picker (double-width masked encoder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_any_valid
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_mask;
    logic [2*NUM_REQ-1:0] w_masked;
    logic [2*NUM_REQ-1:0] w_pick;
    logic [IDX_W:0]       w_shamt;

    // One extra bit keeps last_grant+1 from wrapping when NUM_REQ is a power of two.
    assign w_shamt  = {1'b0, i_last_grant} + (IDX_W+1)'(1);
    assign w_dbl    = {i_valid, i_valid};
    assign w_mask   = {(2*NUM_REQ){1'b1}} << w_shamt;
    assign w_masked = w_dbl & w_mask;
    assign w_pick   = w_masked & (~w_masked + (2*NUM_REQ)'(1));

    generate
        for (genvar j = 0; j < NUM_REQ; j++) begin : g_fold
            assign o_winner[j] = w_pick[j] | w_pick[j+NUM_REQ];
        end
    endgenerate

    assign o_any_valid = |i_valid;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin packet scheduler sharing one uart_tx among requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*UART_DW-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       tx_trigger_o,
    output logic [UART_DW-1:0]         tx_data_o,
    input  logic                       tx_busy_i,
    input  logic                       tx_done_i
);

    localparam int c_idx_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_burst_w = $clog2(MAX_BURST + 1);
    localparam int c_idle_w  = $clog2(IDLE_TIMEOUT + 1);

    uart_arb_state_t        r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [c_idx_w-1:0]     r_last_grant;
    logic [c_burst_w-1:0]   r_burst_cnt;
    logic [c_idle_w-1:0]    r_idle_cnt;
    logic                   r_last_seen;
    logic                   r_tx_trigger;
    logic [UART_DW-1:0]     r_tx_data;

    logic [NUM_REQ-1:0]     w_winner;
    logic                   w_any_valid;
    logic [c_idx_w-1:0]     w_grant_idx;
    logic [UART_DW-1:0]     w_owner_data;
    logic                   w_owner_last;
    logic                   w_owner_valid;
    logic                   w_accept;
    logic [c_idle_w-1:0]    w_idle_inc;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_pick (
        .i_valid      (req_valid_i),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_valid  (w_any_valid)
    );

    always_comb begin
        w_grant_idx  = '0;
        w_owner_data = '0;
        w_owner_last = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant[j]) begin
                w_grant_idx  = c_idx_w'(j);
                w_owner_data = req_data_i[j*UART_DW +: UART_DW];
                w_owner_last = req_last_i[j];
            end
        end
    end

    // Ready depends only on state, grant and busy so no valid->ready loop exists.
    assign req_ready_o   = (r_state == SEND && !tx_busy_i) ? r_grant : '0;
    assign w_owner_valid = |(req_valid_i & r_grant);
    assign w_accept      = |(req_valid_i & req_ready_o);
    assign w_idle_inc    = (r_idle_cnt == c_idle_w'(IDLE_TIMEOUT)) ? r_idle_cnt
                                                                  : r_idle_cnt + c_idle_w'(1);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_idx_w'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
            r_idle_cnt   <= '0;
            r_last_seen  <= 1'b0;
            r_tx_trigger <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            r_tx_trigger <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant     <= w_winner;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_tx_data    <= w_owner_data;
                        r_burst_cnt  <= r_burst_cnt + c_burst_w'(1);
                        r_last_seen  <= w_owner_last;
                        r_idle_cnt   <= '0;
                        r_tx_trigger <= 1'b1;
                        r_state      <= LAUNCH;
                    end else if (!w_owner_valid) begin
                        if (w_idle_inc == c_idle_w'(IDLE_TIMEOUT)) begin
                            r_last_grant <= w_grant_idx;
                            r_grant      <= '0;
                            r_state      <= IDLE;
                        end
                        r_idle_cnt <= w_idle_inc;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_i) begin
                        if (r_last_seen || r_burst_cnt == c_burst_w'(MAX_BURST)) begin
                            r_last_grant <= w_grant_idx;
                            r_grant      <= '0;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= SEND;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign tx_trigger_o = r_tx_trigger;
    assign tx_data_o    = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a uart_tx frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int FRAME = 10;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        rv [2];
    logic [7:0]  rd [2];
    logic        rl [2];
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        tx_trigger;
    logic [7:0]  tx_data;
    logic        tx_busy_m, busy_force, tx_busy;
    logic        tx_done_m, done_force, tx_done;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   trig_seen = 0;

    assign req_valid = {rv[1], rv[0]};
    assign req_data  = {rd[1], rd[0]};
    assign req_last  = {rl[1], rl[0]};
    assign tx_busy   = tx_busy_m | busy_force;
    assign tx_done   = tx_done_m | done_force;

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .MAX_BURST    (16),
        .IDLE_TIMEOUT (64)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .tx_trigger_o (tx_trigger),
        .tx_data_o    (tx_data),
        .tx_busy_i    (tx_busy),
        .tx_done_i    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic drive_byte(input int idx, input logic [7:0] d, input logic lst);
        bit ok;
        ok = 1'b0;
        rv[idx] = 1'b1;
        rd[idx] = d;
        rl[idx] = lst;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rv[idx] = 1'b0;
        rl[idx] = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req%0d byte %0h never accepted", idx, d);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no tx_done within bound");
        end
    endtask

    task automatic wait_quiet();
        bit quiet;
        quiet = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (grant == 2'b00 && !tx_busy_m && !tx_done_m) begin
                quiet = 1'b1;
                break;
            end
        end
        if (!quiet) begin
            total++;
            bad++;
            $display("FAIL quiet_timeout: grant=%0b busy=%0b", grant, tx_busy_m);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // uart_tx stand-in: busy for a frame after a trigger, then a done pulse.
    initial begin
        tx_busy_m = 1'b0;
        tx_done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && tx_trigger) begin
                @(posedge clk);
                #1 tx_busy_m = 1'b1;
                repeat (FRAME - 1) @(posedge clk);
                #1;
                tx_busy_m = 1'b0;
                tx_done_m = 1'b1;
                @(posedge clk);
                #1 tx_done_m = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (tx_trigger) begin
                    trig_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_trigger: data %0h grant %0b, nothing expected",
                                 tx_data, grant);
                    end else begin
                        e = exp_q.pop_front();
                        check("trig_data", {24'h0, tx_data}, {24'h0, e.data});
                        check("trig_grant", {30'h0, grant}, 32'(1) << e.idx);
                    end
                end
                if (req_ready != 2'b00) begin
                    check("ready_in_grant", {30'h0, req_ready & ~grant}, 32'h0);
                    check("ready_onehot", 32'($countones(req_ready)), 32'h1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int stall_bad;
        resetn     = 1'b0;
        busy_force = 1'b0;
        done_force = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0;
            rd[i] = 8'h00;
            rl[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_ready", {30'h0, req_ready}, 32'h0);
        check("rst_trig", {31'h0, tx_trigger}, 32'h0);
        check("rst_data", {24'h0, tx_data}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Reset in WAIT while done pulses
        push(0, 8'h55);
        drive_byte(0, 8'h55, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (tx_busy_m) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resetn     = 1'b0;
        done_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_grant", {30'h0, grant}, 32'h0);
        check("midrst_ready", {30'h0, req_ready}, 32'h0);
        check("midrst_trig", {31'h0, tx_trigger}, 32'h0);
        check("midrst_data", {24'h0, tx_data}, 32'h0);
        @(posedge clk);
        #1 done_force = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        n0 = trig_seen;
        repeat (5) @(negedge clk);
        check("postrst_no_trig", 32'(trig_seen), 32'(n0));
        check("postrst_grant", {30'h0, grant}, 32'h0);
        wait_quiet();

        // Single packet with latency probe on the first byte
        push(0, 8'h41);
        push(0, 8'h42);
        push(0, 8'h43);
        rv[0] = 1'b1;
        rd[0] = 8'h41;
        rl[0] = 1'b0;
        @(negedge clk);
        check("lat_c0_grant", {30'h0, grant}, 32'h0);
        @(negedge clk);
        check("lat_c1_grant", {30'h0, grant}, 32'h1);
        check("lat_c1_ready", {30'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        check("lat_c2_trig", {31'h0, tx_trigger}, 32'h1);
        drive_byte(0, 8'h42, 1'b0);
        drive_byte(0, 8'h43, 1'b1);
        wait_done();
        check("pkt_grant_at_done", {30'h0, grant}, 32'h1);
        @(negedge clk);
        check("pkt_release", {30'h0, grant}, 32'h0);
        wait_quiet();

        // Fairness: last owner was req0, so req1 leads and they alternate
        for (int p = 0; p < 8; p++) begin
            if (p % 2 == 0) begin
                push(1, 8'(8'hB0 + p));
                push(1, 8'(8'hB1 + p));
            end else begin
                push(0, 8'(8'hA0 + p - 1));
                push(0, 8'(8'hA1 + p - 1));
            end
        end
        fork
            for (int k = 0; k < 4; k++) begin
                drive_byte(0, 8'(8'hA0 + 2*k), 1'b0);
                drive_byte(0, 8'(8'hA1 + 2*k), 1'b1);
            end
            for (int k = 0; k < 4; k++) begin
                drive_byte(1, 8'(8'hB0 + 2*k), 1'b0);
                drive_byte(1, 8'(8'hB1 + 2*k), 1'b1);
            end
        join
        wait_quiet();
        check("fair_q_empty", 32'(exp_q.size()), 32'h0);

        // Burst cap: req1 cut after 16 bytes, req0 served, req1 resumes
        for (int k = 0; k < 16; k++) push(1, 8'(8'hC0 + k));
        push(0, 8'h5A);
        for (int k = 16; k < 20; k++) push(1, 8'(8'hC0 + k));
        fork
            for (int k = 0; k < 20; k++) drive_byte(1, 8'(8'hC0 + k), (k == 19));
            drive_byte(0, 8'h5A, 1'b1);
        join
        wait_quiet();
        check("burst_q_empty", 32'(exp_q.size()), 32'h0);

        // Idle timeout with req1 pending
        push(0, 8'h77);
        drive_byte(0, 8'h77, 1'b0);
        push(1, 8'h88);
        rv[1] = 1'b1;
        rd[1] = 8'h88;
        rl[1] = 1'b1;
        fork
            drive_byte(1, 8'h88, 1'b1);
            begin
                wait_done();
                @(negedge clk);
                check("to_starve1_grant", {30'h0, grant}, 32'h1);
                repeat (63) @(negedge clk);
                check("to_starve64_grant", {30'h0, grant}, 32'h1);
                @(negedge clk);
                check("to_clear_grant", {30'h0, grant}, 32'h0);
                @(negedge clk);
                check("to_next_grant", {30'h0, grant}, 32'h2);
            end
        join
        wait_quiet();

        // Busy stall: owner valid but serializer busy
        busy_force = 1'b1;
        rv[0] = 1'b1;
        rd[0] = 8'h99;
        rl[0] = 1'b1;
        @(negedge clk);
        stall_bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00 || grant != 2'b01 || tx_trigger) stall_bad++;
        end
        check("stall_bad_cycles", 32'(stall_bad), 32'h0);
        push(0, 8'h99);
        @(posedge clk);
        #1 busy_force = 1'b0;
        drive_byte(0, 8'h99, 1'b1);
        wait_quiet();
        check("final_q_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
